// File: rtl/des_subkey_stream.sv
// DES key schedule streamer: accepts one key, emits the sixteen round subkeys
// in forward (encrypt) or reverse (decrypt) order over a valid/ready handshake.
module des_subkey_stream #(
  parameter int KEY_WIDTH    = 64,
  parameter int SUBKEY_WIDTH = 48,
  parameter int ROUNDS       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [KEY_WIDTH-1:0]    key_in,
  input  logic                    decrypt,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic [SUBKEY_WIDTH-1:0] subkey,
  output logic [3:0]              round_idx,
  output logic                    subkey_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  // Bit n-1 set where the shift schedule entry S[n] is 1 (n = 1,2,9,16); all others shift by 2.
  localparam logic [15:0] ONE_SHIFT = 16'h8103;

  // PC-1 and PC-2 in FIPS 1-based bit numbering, first table entry in the MSB slot.
  localparam logic [56*7-1:0] PC1_TAB = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [48*6-1:0] PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // FIPS bit b of a vector of width W lives at index W-b.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [6:0]  e;
    logic [5:0]  bi;
    r = '0;
    for (int j = 0; j < 56; j++) begin
      e       = PC1_TAB[(55-j)*7 +: 7];
      bi      = 6'(7'd64 - e);
      r[55-j] = k[bi];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  e;
    logic [5:0]  bi;
    r = '0;
    for (int j = 0; j < 48; j++) begin
      e       = PC2_TAB[(47-j)*6 +: 6];
      bi      = 6'd56 - e;
      r[47-j] = cd[bi];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  logic [0:0]  state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  idx_q, idx_d;
  logic        mode_q, mode_d;

  logic [55:0] key_cd;
  logic [3:0]  sbit;
  logic        two;

  assign key_cd = pc1(key_in);

  // Schedule position of the next step: forward walks S[idx+2], reverse walks S[16-idx].
  assign sbit = mode_q ? 4'(4'd15 - idx_q) : 4'(idx_q + 4'd1);
  assign two  = ~ONE_SHIFT[sbit];

  // Next-state: key load in IDLE, one rotation step per accepted subkey in EMIT.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          // Encrypt pre-rotates to C1/D1; decrypt keeps C0/D0, which equals C16/D16.
          c_d     = decrypt ? key_cd[55:28] : rotl(key_cd[55:28], 1'b0);
          d_d     = decrypt ? key_cd[27:0]  : rotl(key_cd[27:0], 1'b0);
          mode_d  = decrypt;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      default: begin
        if (subkey_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
            c_d   = mode_q ? rotr(c_q, two) : rotl(c_q, two);
            d_d   = mode_q ? rotr(d_q, two) : rotl(d_q, two);
          end
        end
      end
    endcase
  end

  // State registers; reset aborts any partial sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  // Outputs depend only on registered state, so no ready/valid feed-through exists.
  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = (state_q == EMIT);
  assign subkey       = subkey_valid ? pc2({c_q, d_q}) : '0;
  assign round_idx    = idx_q;
  assign subkey_last  = subkey_valid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_des_subkey_stream.sv
// Randomised bench for des_subkey_stream against a cumulative-rotation key schedule model.
module tb_des_subkey_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic [3:0]  round_idx;
  logic        subkey_last;

  int nvec = 0;
  int nerr = 0;

  logic [47:0] obs[16];
  logic [47:0] enc_obs[16];

  int pc1_t[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                    23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48,
                    44,49,39,56,34,53, 46,42,50,36,29,32};
  int sched[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  des_subkey_stream dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .decrypt(decrypt),
    .subkey_valid(subkey_valid), .subkey_ready(subkey_ready), .subkey(subkey),
    .round_idx(round_idx), .subkey_last(subkey_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Kn = PC-2 of (C0,D0) each rotated left by the sum of the first n schedule entries.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int n);
    bit cb[56];
    bit rb[56];
    int tot;
    logic [47:0] k;
    for (int j = 0; j < 56; j++) cb[j] = key[64 - pc1_t[j]];
    tot = 0;
    for (int i = 0; i < n; i++) tot += sched[i];
    for (int i = 0; i < 28; i++) begin
      rb[i]      = cb[(i + tot) % 28];
      rb[28 + i] = cb[28 + (i + tot) % 28];
    end
    for (int j = 0; j < 48; j++) k[47 - j] = rb[pc2_t[j] - 1];
    return k;
  endfunction

  // Entered and left at a negedge with the DUT idle. rmode: 0 ready high, 1 pattern 1,0,0, 2 random.
  task automatic run_key(input logic [63:0] key, input logic dec, input int rmode,
                         input bit pulse, input bit hold, input logic [63:0] nkey);
    logic [47:0] exp[16];
    int p, cyc;
    bit pulsed, pact, r;
    for (int i = 0; i < 16; i++) exp[i] = dec ? model_k(key, 16 - i) : model_k(key, i + 1);
    chk("key_ready_idle", key_ready, 1);
    key_in = key; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin key_in = nkey; decrypt = 1'b0; end
    else key_valid = 1'b0;
    chk("first_latency", subkey_valid, 1);
    p = 0; cyc = 0; pulsed = 0; pact = 0;
    while (p < 16 && cyc < 200) begin
      if (pact) begin key_valid = 1'b0; pact = 0; end
      chk("valid", subkey_valid, 1);
      chk("key_ready_emit", key_ready, 0);
      chk("round_idx", round_idx, p);
      chk("subkey", subkey, exp[p]);
      chk("last", subkey_last, (p == 15));
      obs[p] = subkey;
      case (rmode)
        0: r = 1;
        1: r = (cyc % 3 == 0);
        default: r = ($urandom_range(0, 1) == 1);
      endcase
      subkey_ready = r;
      if (pulse && p == 5 && !pulsed) begin
        key_valid = 1'b1; key_in = {$urandom, $urandom}; decrypt = $urandom_range(0, 1);
        pulsed = 1; pact = 1;
      end
      if (r) p++;
      cyc++;
      @(negedge clk);
    end
    chk("no_timeout", p, 16);
    chk("done_valid", subkey_valid, 0);
    chk("done_last", subkey_last, 0);
    chk("done_key_ready", key_ready, 1);
    if (!hold) key_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk("rst_valid", subkey_valid, 0);
    chk("rst_subkey", subkey, 0);
    chk("rst_last", subkey_last, 0);
    chk("rst_idx", round_idx, 0);
    rst_n = 1'b1;
    chk("rst_key_ready", key_ready, 1);

    // Reference key, encrypt then decrypt.
    run_key(64'h133457799BBCDFF1, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) enc_obs[i] = obs[i];
    chk("std_enc_k1", enc_obs[0], 48'h1B02EFFC7072);
    chk("std_enc_k2", enc_obs[1], 48'h79AED9DBC9E5);
    chk("std_enc_k16", enc_obs[15], 48'hCB3D8B0E17F5);
    run_key(64'h133457799BBCDFF1, 1'b1, 0, 0, 0, 0);
    chk("std_dec_0", obs[0], 48'hCB3D8B0E17F5);
    chk("std_dec_14", obs[14], 48'h79AED9DBC9E5);
    chk("std_dec_15", obs[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_reverse", obs[i], enc_obs[15 - i]);

    // Backpressure pattern with a stray key pulse mid-sequence.
    run_key(64'h133457799BBCDFF1, 1'b0, 1, 1, 0, 0);

    // Parity-only key yields all-zero subkeys.
    run_key(64'h0101010101010101, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) chk("parity_zero", obs[i], 0);

    // Reset in the middle of a sequence.
    key_in = 64'h0123456789ABCDEF; decrypt = 1'b0; key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0; subkey_ready = 1'b1;
    for (int i = 0; i < 20 && round_idx != 4'd7; i++) @(negedge clk);
    chk("mid_idx", round_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", subkey_valid, 0);
    chk("async_idx", round_idx, 0);
    chk("async_subkey", subkey, 0);
    chk("async_key_ready", key_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_key(64'hFEDCBA9876543210, 1'b1, 0, 0, 0, 0);

    // Back-to-back keys, second all-ones.
    run_key(64'h0F1E2D3C4B5A6978, 1'b0, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF);
    run_key(64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) chk("ones", obs[i], 48'hFFFFFFFFFFFF);

    // Random keys, directions and backpressure.
    for (int t = 0; t < 8; t++)
      run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)), 2, (t % 2 == 1), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/des_subkey_stream.md
Name: des_subkey_stream

Overview:
- Sequential DES key schedule; pairs with the S-box stages in the round datapath.
- Accepts one 64-bit key and emits the sixteen 48-bit round subkeys, one per handshake.
- Emits in forward order K1..K16 for encryption, or reverse order K16..K1 for decryption.
- Feeds the round pipeline so the same datapath runs in either direction.

Parameters:
- KEY_WIDTH, 64, input key width including parity bits; fixed by DES.
- SUBKEY_WIDTH, 48, round subkey width; fixed by DES.
- ROUNDS, 16, number of subkeys emitted per key.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- key_valid  input  1  key_in and decrypt are valid.
- key_ready  output  1  block can accept a key.
- key_in  input  64  DES key; FIPS bit 1 = key_in[63]; parity bits ignored.
- decrypt  input  1  0 = emit K1..K16; 1 = emit K16..K1; sampled with the key.
- subkey_valid  output  1  subkey is valid.
- subkey_ready  input  1  consumer accepts the subkey.
- subkey  output  48  PC-2(C,D); FIPS bit 1 = subkey[47].
- round_idx  output  4  emission position, 0..15.
- subkey_last  output  1  high with subkey_valid when round_idx = 15.

Behaviour:
- Clock and reset
  - One clock; reset is asynchronous and active-low on rst_n.
- Reset values
  - State IDLE; C = D = 0; round_idx = 0; mode = 0.
  - key_ready = 1 once rst_n deasserts; subkey_valid = 0; subkey = 0; subkey_last = 0.
- Permutations and rotation schedule
  - PC-1 and PC-2 are the FIPS 46-3 tables.
  - C and D are 28-bit registers.
  - Shift schedule S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- FSM states: IDLE and EMIT.
- IDLE
  - key_ready = 1, subkey_valid = 0.
  - Key accept: on key_valid & key_ready, load (C,D) = PC-1(key_in) and latch mode = decrypt.
  - Encrypt load also applies rotate-left by 1 to C and D, so the registers hold C1/D1.
  - Decrypt load stores C0/D0 unrotated, which equals C16/D16.
  - Next state EMIT, round_idx = 0.
- EMIT
  - key_ready = 0, subkey_valid = 1; subkey = PC-2(C,D), combinational from the registers.
  - Latency: the first subkey is valid the cycle after key acceptance.
- Stall
  - While subkey_valid & !subkey_ready: subkey, round_idx and subkey_last hold stable.
- Transfer
  - On subkey_valid & subkey_ready with round_idx < 15, increment round_idx.
  - Encrypt: rotate C,D left by S[round_idx+2].
  - Decrypt: rotate C,D right by S[16-round_idx].
- Completion
  - Transfer with round_idx = 15 returns to IDLE.
  - key_ready = 1 the next cycle; no back-to-back overlap of keys.
- Output rate and arbitration
  - Maximum rate: one subkey per cycle when subkey_ready is held high; 17 cycles per key including accept.
  - key_valid during EMIT is ignored; the key is not consumed, so the producer must hold it.
  - Wrap: cumulative rotation totals 28 = identity, so no explicit reload is needed between keys.
- Reset mid-operation
  - Asserting rst_n low at any point aborts immediately to the reset values.
  - Partial sequences are discarded; the next key starts cleanly.
- Combinational paths
  - No combinational path from subkey_ready to key_ready or from key_valid to subkey_valid.

Test Plan:
- Encrypt order
  - Stimulus: key 0x133457799BBCDFF1, decrypt = 0, subkey_ready held 1.
  - Required: 16 consecutive cycles with subkey[0] = 0x1B02EFFC7072, subkey[1] = 0x79AED9DBC9E5, subkey[15] = 0xCB3D8B0E17F5.
  - Required: subkey_last high only on round 15; key_ready high the following cycle.
- Decrypt order
  - Stimulus: same key, decrypt = 1.
  - Required: subkey[0] = 0xCB3D8B0E17F5, subkey[14] = 0x79AED9DBC9E5, subkey[15] = 0x1B02EFFC7072.
  - Required: full sequence is the exact reverse of the encrypt run.
- Backpressure
  - Stimulus: encrypt run with subkey_ready toggled 1,0,0,1,...
  - Required: subkey, round_idx and subkey_last stable through stalls; all 16 values correct and none dropped or duplicated.
- Parity and key handling
  - Stimulus 1: key 0x0101010101010101 (parity bits only).
  - Required: all 16 subkeys = 0.
  - Stimulus 2: key_valid pulsed during EMIT.
  - Required: ignored; key_ready stays 0.
- Reset mid-operation
  - Stimulus: assert rst_n low at round_idx = 7, then load a new key with decrypt = 1.
  - Required: subkey_valid drops asynchronously; new sequence starts at round_idx = 0 with correct K16.
- Back-to-back keys
  - Stimulus: two keys presented continuously, the second one all-ones 0xFFFFFFFFFFFFFFFF.
  - Required: second sequence starts exactly 1 cycle after the first completes; all subkeys = 0xFFFFFFFFFFFF.
